// File: rtl/instr_mem_prog.sv
// ----------------------------------------------------------------------------
// instr_mem_prog
//   Run-time programmable instruction memory for the fetch stage.
//   After reset a serial load port fills DEPTH words starting at word 0. Once
//   the last word is written the block serves fetch requests with a one-cycle
//   registered latency. A pc that is not below DEPTH returns NOP_WORD and
//   flags addr_err. A prog_en pulse in RUN restarts the load at word 0.
//
// Ports
//   clk_MI       in   1       clock, rising edge
//   reset        in   1       asynchronous, active-high reset
//   prog_en      in   1       start / restart a load at word 0 (IDLE or RUN)
//   prog_valid   in   1       prog_data holds a word this cycle
//   prog_data    in   DATA_W  word to store at the write pointer
//   prog_ready   out  1       high while loading; transfer = prog_valid & prog_ready
//   prog_done    out  1       single-cycle pulse after the last word is written
//   fetch_req    in   1       fetch request, sampled together with pc
//   pc           in   ADDR_W  word address to fetch
//   fetch_valid  out  1       instrucao / addr_err valid this cycle
//   instrucao    out  DATA_W  fetched word; holds its value while fetch_valid=0
//   addr_err     out  1       with fetch_valid: pc >= DEPTH, instrucao = NOP_WORD
// ----------------------------------------------------------------------------
module instr_mem_prog #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       DEPTH    = 42,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk_MI,
    input  logic              reset,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instrucao,
    output logic              addr_err
);

    // One extra bit so the range compare stays correct when DEPTH == 2**ADDR_W.
    localparam int unsigned       CMP_W     = ADDR_W + 1;
    localparam logic [CMP_W-1:0]  DEPTH_CMP = CMP_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic                prog_ready_q, prog_ready_d;
    logic                prog_done_q, prog_done_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic                addr_err_q, addr_err_d;
    logic [DATA_W-1:0]   instr_q, instr_d;

    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                pc_in_range;
    logic [DATA_W-1:0]   rd_word;

    // Out-of-range fetches never touch the array.
    assign pc_in_range = {1'b0, pc} < DEPTH_CMP;
    assign rd_word     = pc_in_range ? mem_q[pc] : NOP_WORD;

    // Next-state, write enable and registered-output next values.
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        prog_done_d   = 1'b0;
        fetch_valid_d = 1'b0;
        addr_err_d    = 1'b0;
        instr_d       = instr_q;
        mem_we        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // fetch_req is ignored here; prog_en wins if both arrive.
                if (prog_en) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                end
            end
            S_LOAD: begin
                // prog_en and fetch_req are ignored until the image is complete.
                if (prog_valid) begin
                    mem_we = 1'b1;
                    if (wptr_q == LAST_WORD) begin
                        state_d     = S_RUN;
                        prog_done_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + ADDR_W'(1);
                    end
                end
            end
            S_RUN: begin
                // A reload drops any fetch presented on the same edge.
                if (prog_en) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                end else if (fetch_req) begin
                    fetch_valid_d = 1'b1;
                    addr_err_d    = ~pc_in_range;
                    instr_d       = rd_word;
                end
            end
            default: begin
                state_d = S_IDLE;
                wptr_d  = '0;
            end
        endcase

        prog_ready_d = (state_d == S_LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk_MI or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            prog_ready_q  <= 1'b0;
            prog_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            instr_q       <= '0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            prog_ready_q  <= prog_ready_d;
            prog_done_q   <= prog_done_d;
            fetch_valid_q <= fetch_valid_d;
            addr_err_q    <= addr_err_d;
            instr_q       <= instr_d;
        end
    end

    // Instruction array; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk_MI) begin
        if (mem_we) begin
            mem_q[wptr_q] <= prog_data;
        end
    end

    assign prog_ready  = prog_ready_q;
    assign prog_done   = prog_done_q;
    assign fetch_valid = fetch_valid_q;
    assign instrucao   = instr_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_prog
//   Self-checking bench for instr_mem_prog: a reference model predicts every
//   cycle's outputs into a scoreboard queue, plus table-driven fetch vectors
//   and hand-written reset / reload sequences with constant expectations.
// ----------------------------------------------------------------------------
module tb_instr_mem_prog;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 42;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic              clk_MI = 1'b0;
    logic              reset  = 1'b1;
    logic              prog_en = 1'b0;
    logic              prog_valid = 1'b0;
    logic [DATA_W-1:0] prog_data = '0;
    logic              prog_ready;
    logic              prog_done;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              fetch_valid;
    logic [DATA_W-1:0] instrucao;
    logic              addr_err;

    instr_mem_prog #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk_MI      (clk_MI),
        .reset       (reset),
        .prog_en     (prog_en),
        .prog_valid  (prog_valid),
        .prog_data   (prog_data),
        .prog_ready  (prog_ready),
        .prog_done   (prog_done),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .instrucao   (instrucao),
        .addr_err    (addr_err)
    );

    always #5 clk_MI = ~clk_MI;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        err;
        logic        ready;
        logic        done;
    } exp_t;

    typedef struct {
        logic [5:0]  pc;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    int          m_state = M_IDLE;
    int          m_wptr  = 0;
    logic [15:0] m_mem [64];
    logic [15:0] m_instr = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Predict the edge with the current inputs, advance one clock, compare.
    task automatic cyc();
        exp_t e;
        e.valid = 1'b0;
        e.err   = 1'b0;
        e.done  = 1'b0;
        case (m_state)
            M_IDLE: if (prog_en) begin m_state = M_LOAD; m_wptr = 0; end
            M_LOAD: if (prog_valid) begin
                m_mem[m_wptr] = prog_data;
                if (m_wptr == DEPTH - 1) begin m_state = M_RUN; e.done = 1'b1; end
                else m_wptr++;
            end
            M_RUN: begin
                if (prog_en) begin
                    m_state = M_LOAD;
                    m_wptr  = 0;
                end else if (fetch_req) begin
                    e.valid = 1'b1;
                    if (int'(pc) >= DEPTH) begin e.err = 1'b1; m_instr = 16'h0000; end
                    else m_instr = m_mem[pc];
                end
            end
            default: m_state = M_IDLE;
        endcase
        e.data  = m_instr;
        e.ready = (m_state == M_LOAD);
        sb.push_back(e);

        @(posedge clk_MI);
        #1;
        e = sb.pop_front();
        chk("fetch_valid", 32'(fetch_valid), 32'(e.valid));
        chk("instrucao",   32'(instrucao),   32'(e.data));
        if (e.valid) chk("addr_err", 32'(addr_err), 32'(e.err));
        chk("prog_ready",  32'(prog_ready),  32'(e.ready));
        chk("prog_done",   32'(prog_done),   32'(e.done));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_prog_ready"},  32'(prog_ready),  32'd0);
        chk({tag, "_prog_done"},   32'(prog_done),   32'd0);
        chk({tag, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
        chk({tag, "_instrucao"},   32'(instrucao),   32'd0);
        chk({tag, "_addr_err"},    32'(addr_err),    32'd0);
    endtask

    // Called at posedge+1: assert reset mid-cycle, check outputs with no edge.
    task automatic reset_mid();
        #2 reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        m_state = M_IDLE;
        m_wptr  = 0;
        m_instr = 16'h0000;
        prog_en = 1'b0; prog_valid = 1'b0; fetch_req = 1'b0;
        #2 reset = 1'b0;
    endtask

    // Full image load: word i = base + step*i, optional stalls and noise.
    task automatic load_image(input logic [15:0] base, input logic [15:0] step,
                              input bit stall, input bit noise, input bit fetch_with_en);
        prog_en   = 1'b1;
        fetch_req = fetch_with_en;
        pc        = 6'd5;
        cyc();
        chk("load_start_ready", 32'(prog_ready), 32'd1);
        chk("load_start_fv",    32'(fetch_valid), 32'd0);
        prog_en   = 1'b0;
        fetch_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stall && (i % 2 == 1)) begin
                prog_valid = 1'b0;
                prog_data  = 16'hDEAD;
                fetch_req  = 1'b1;
                pc         = 6'(i);
                cyc();
                cyc();
                fetch_req  = 1'b0;
            end
            prog_valid = 1'b1;
            prog_data  = 16'(base + step * 16'(i));
            prog_en    = noise && (i == 20);
            cyc();
            prog_en    = 1'b0;
        end
        chk("load_done_pulse", 32'(prog_done), 32'd1);
        prog_valid = 1'b0;
        cyc();
        chk("load_done_fall", 32'(prog_done), 32'd0);
    endtask

    task automatic readback(input logic [15:0] base, input logic [15:0] step);
        for (int i = 0; i < DEPTH; i++) begin
            fetch_req = 1'b1;
            pc        = 6'(i);
            cyc();
            chk("rb_data",  32'(instrucao), 32'(16'(base + step * 16'(i))));
            chk("rb_valid", 32'(fetch_valid), 32'd1);
        end
        fetch_req = 1'b0;
        cyc();
        chk("rb_hold", 32'(instrucao), 32'(16'(base + step * 16'(DEPTH - 1))));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = 16'h0000;
        vecs[0] = '{6'd42, 16'h0000, 1'b1};
        vecs[1] = '{6'd63, 16'h0000, 1'b1};
        vecs[2] = '{6'd0,  16'hA000, 1'b0};
        vecs[3] = '{6'd41, 16'hA029, 1'b0};
        vecs[4] = '{6'd43, 16'h0000, 1'b1};
        vecs[5] = '{6'd21, 16'hA015, 1'b0};

        // Power-on reset.
        repeat (2) @(posedge clk_MI);
        #1;
        chk_zero("por");
        reset = 1'b0;

        // Straight load of A000+i, then back-to-back readback.
        load_image(16'hA000, 16'h0001, 1'b0, 1'b0, 1'b0);
        readback(16'hA000, 16'h0001);

        // Table vectors, back-to-back, including out-of-range pcs.
        for (int i = 0; i < 6; i++) begin
            fetch_req = 1'b1;
            pc        = vecs[i].pc;
            cyc();
            chk("vec_valid", 32'(fetch_valid), 32'd1);
            chk("vec_data",  32'(instrucao),   32'(vecs[i].exp_data));
            chk("vec_err",   32'(addr_err),    32'(vecs[i].exp_err));
        end

        // Async reset while a fetch result is being presented.
        fetch_req = 1'b1;
        pc        = 6'd3;
        cyc();
        chk("pre_reset_fv", 32'(fetch_valid), 32'd1);
        reset_mid();

        // IDLE: prog_en and fetch_req together -> load wins, no result.
        prog_en   = 1'b1;
        fetch_req = 1'b1;
        pc        = 6'd1;
        cyc();
        chk("idle_both_fv",    32'(fetch_valid), 32'd0);
        chk("idle_both_ready", 32'(prog_ready),  32'd1);
        prog_en   = 1'b0;
        fetch_req = 1'b0;

        // Partial load of 10 words, then reset mid-load.
        for (int i = 0; i < 10; i++) begin
            prog_valid = 1'b1;
            prog_data  = 16'(16'hC000 + 16'(i));
            cyc();
        end
        prog_valid = 1'b0;
        reset_mid();
        chk("after_reset_ready", 32'(prog_ready), 32'd0);

        // Fetch in IDLE is ignored.
        fetch_req = 1'b1;
        pc        = 6'd2;
        cyc();
        cyc();
        chk("idle_fetch_fv", 32'(fetch_valid), 32'd0);
        fetch_req = 1'b0;

        // Stalled reload from word 0 with fetch attempts during stalls.
        load_image(16'hB000, 16'h0001, 1'b1, 1'b0, 1'b0);
        readback(16'hB000, 16'h0001);

        // Reload in RUN with a same-edge fetch; prog_en noise mid-load.
        load_image(16'hD000, 16'h0003, 1'b0, 1'b1, 1'b1);
        readback(16'hD000, 16'h0003);

        fetch_req = 1'b1;
        pc        = 6'd63;
        cyc();
        chk("final_oor_err",  32'(addr_err),  32'd1);
        chk("final_oor_data", 32'(instrucao), 32'd0);
        fetch_req = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
